hazard_scoreboard: RTL and testbench

Parametrised hazard-detection and forwarding-control unit for the pipelined CPU. It replaces the fixed load-use bubble logic and fixed two-source forwarding unit with a registered scoreboard of in-flight destination registers. The scoreboard covers a configurable number of post-issue stages and source operands. It sits beside the ID stage, drives the IF/ID hold and EX bubble, and delivers registered forwarding selects to the EX operand muxes.

---
 rtl/hazard_scoreboard_pkg.sv | 29 ++
 rtl/hazard_scoreboard_if.sv | 34 +++
 rtl/hazard_slot_pipe.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 138 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: forwarding-select encoding, the
// flat slot field layout and default geometry. Optional forwarding is enabled
// with the HAZARD_FORWARD_EN macro (see hazard_scoreboard.sv).
package hazard_scoreboard_pkg;

  // Select value meaning "take register-file data"
  localparam int unsigned FWD_RF = 0;

  localparam int unsigned DEF_REG_AW     = 4;
  localparam int unsigned DEF_NSRC       = 2;
  localparam int unsigned DEF_DEPTH      = 3;
  localparam int unsigned DEF_LOAD_READY = 2;

  // Bit positions inside one flattened slot {rd, load, wr, valid}
  localparam int unsigned SLOT_VALID  = 0;
  localparam int unsigned SLOT_WR     = 1;
  localparam int unsigned SLOT_LOAD   = 2;
  localparam int unsigned SLOT_RD_LSB = 3;

  function automatic int unsigned slot_width(int unsigned reg_aw);
    return reg_aw + 3;
  endfunction

  // Forwarding-select width; never narrower than one bit
  function automatic int unsigned fsw(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard unit bundle. master = ID/EX pipeline side, slave = the
// hazard scoreboard.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned NSRC   = DEF_NSRC,
  parameter int unsigned DEPTH  = DEF_DEPTH
);
  localparam int unsigned FSW = fsw(DEPTH);

  logic                     id_valid;
  logic [NSRC-1:0]          id_src_en;
  logic [NSRC*REG_AW-1:0]   id_src;
  logic                     id_wr_en;
  logic [REG_AW-1:0]        id_rd;
  logic                     id_is_load;
  logic                     flush;
  logic                     stat_clr;
  logic                     stall;
  logic [NSRC*FSW-1:0]      ex_fwd_sel;
  logic [15:0]              stall_cnt;

  modport master (
    output id_valid, id_src_en, id_src, id_wr_en, id_rd, id_is_load, flush, stat_clr,
    input  stall, ex_fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_src_en, id_src, id_wr_en, id_rd, id_is_load, flush, stat_clr,
    output stall, ex_fwd_sel, stall_cnt
  );

endinterface

// File: rtl/hazard_slot_pipe.sv
// DEPTH-slot shift register of in-flight destination registers. Slot 0 is EX,
// slot DEPTH-1 is WB. Slot 0 takes the issuing instruction or a bubble.
module hazard_slot_pipe
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned SlotW = slot_width(REG_AW)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_i,
  input  logic                   wr_i,
  input  logic [REG_AW-1:0]      rd_i,
  input  logic                   load_i,
  output logic [DEPTH*SlotW-1:0] slots_o
);

  logic [SlotW-1:0]       slot_in;
  logic [DEPTH*SlotW-1:0] slots_d, slots_q;

  // Build the new slot 0 entry; a non-issuing cycle inserts an all-zero bubble
  always_comb begin
    slot_in = '0;
    if (issue_i) begin
      slot_in[SLOT_VALID]                 = 1'b1;
      slot_in[SLOT_WR]                    = wr_i;
      slot_in[SLOT_LOAD]                  = load_i;
      slot_in[SLOT_RD_LSB +: REG_AW]      = rd_i;
    end
    slots_d = {slots_q[(DEPTH-1)*SlotW-1:0], slot_in};
  end

  // Shift every cycle; reset empties the scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q <= '0;
    end else begin
      slots_q <= slots_d;
    end
  end

  assign slots_o = slots_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding control. Matches ID source operands against
// the in-flight scoreboard, raises stall, registers the EX forwarding selects
// and counts stalled cycles.
// Build option: define HAZARD_FORWARD_EN to enable forwarding; otherwise any
// dependency on a not-yet-written-back producer stalls and selects are 0.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW     = DEF_REG_AW,
  parameter int unsigned NSRC       = DEF_NSRC,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned LOAD_READY = DEF_LOAD_READY,
  localparam int unsigned FSW       = fsw(DEPTH)
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave hz
);

  localparam int unsigned SlotW = slot_width(REG_AW);

  logic [DEPTH*SlotW-1:0] slots;
  logic [DEPTH-1:0]       slot_v, slot_wr, slot_ld;
  logic [REG_AW-1:0]      slot_rd [DEPTH];
  logic [NSRC-1:0]        hit, haz;
  logic [FSW-1:0]         hit_k [NSRC];
  logic                   stall, issue;
  logic [15:0]            cnt_d, cnt_q;

  hazard_slot_pipe #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_slot_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue_i (issue),
    .wr_i    (hz.id_wr_en),
    .rd_i    (hz.id_rd),
    .load_i  (hz.id_is_load),
    .slots_o (slots)
  );

  for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
    assign slot_v[k]  = slots[k*SlotW + SLOT_VALID];
    assign slot_wr[k] = slots[k*SlotW + SLOT_WR];
    assign slot_ld[k] = slots[k*SlotW + SLOT_LOAD];
    assign slot_rd[k] = slots[k*SlotW + SLOT_RD_LSB +: REG_AW];
  end

`ifdef HAZARD_FORWARD_EN
  logic [NSRC-1:0]     hit_ld;
  logic [NSRC*FSW-1:0] sel, fwd_sel_d, fwd_sel_q;
`else
  // Load bit only matters when forwarding distinguishes load latency
  logic unused_slot_ld;
  assign unused_slot_ld = ^slot_ld;
`endif

  // Youngest match per source: scan oldest to youngest so the smallest k wins
  always_comb begin
    hit = '0;
    haz = '0;
`ifdef HAZARD_FORWARD_EN
    hit_ld = '0;
    sel    = '0;
`endif
    for (int s = 0; s < NSRC; s++) begin
      hit_k[s] = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (hz.id_src_en[s] && slot_v[k] && slot_wr[k] &&
            (slot_rd[k] == hz.id_src[s*REG_AW +: REG_AW]) &&
            (hz.id_src[s*REG_AW +: REG_AW] != '0)) begin
          hit[s]   = 1'b1;
          hit_k[s] = FSW'(k);
`ifdef HAZARD_FORWARD_EN
          hit_ld[s] = slot_ld[k];
`endif
        end
      end
`ifdef HAZARD_FORWARD_EN
      // Producer reaches slot k+1 by the time the consumer is in EX
      haz[s] = hit[s] & hit_ld[s] & ((32'(hit_k[s]) + 32'd1) < LOAD_READY);
      // A WB-slot producer is covered by register-file write-through
      if (hit[s] && (32'(hit_k[s]) < DEPTH - 1)) begin
        sel[s*FSW +: FSW] = hit_k[s] + FSW'(1);
      end
`else
      haz[s] = hit[s] & (32'(hit_k[s]) < DEPTH - 1);
`endif
    end
  end

  assign stall    = hz.id_valid & ~hz.flush & (|haz);
  assign issue    = hz.id_valid & ~stall & ~hz.flush;
  assign hz.stall = stall;

`ifdef HAZARD_FORWARD_EN
  // Selects follow the instruction into EX; bubbles carry register-file selects
  always_comb begin
    fwd_sel_d = issue ? sel : {NSRC{FSW'(FWD_RF)}};
  end

  // EX forwarding-select register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel_q <= '0;
    end else begin
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign hz.ex_fwd_sel = fwd_sel_q;
`else
  assign hz.ex_fwd_sel = '0;
`endif

  // Saturating stall counter; clear takes priority over an increment
  always_comb begin
    cnt_d = cnt_q;
    if (hz.stat_clr) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hz.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic against a distance-based reference model, and a counter saturation
// run on a deep instance.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int unsigned REG_AW = 4, NSRC = 2, DEPTH = 3, LOAD_READY = 2, FSW = 2;
  localparam int unsigned S_DEPTH = 16, S_LR = 15;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, rst_n_sat;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(REG_AW), .NSRC(NSRC), .DEPTH(DEPTH)) bus ();
  hazard_scoreboard_if #(.REG_AW(REG_AW), .NSRC(NSRC), .DEPTH(S_DEPTH)) sbus ();

  hazard_scoreboard #(
    .REG_AW(REG_AW), .NSRC(NSRC), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  hazard_scoreboard #(
    .REG_AW(REG_AW), .NSRC(NSRC), .DEPTH(S_DEPTH), .LOAD_READY(S_LR)
  ) sdut (
    .clk   (clk),
    .rst_n (rst_n_sat),
    .hz    (sbus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: hist[d-1] is the instruction issued d cycles ago
  typedef struct { bit v; bit wr; bit ld; int rd; } ins_t;
  ins_t hist [DEPTH];
  bit   m_stall;
  int   m_sel [NSRC];
  int   m_sel_q [NSRC];
  int   m_cnt;

  bit i_v, i_wr, i_ld, i_fl, i_clr;
  bit i_en [NSRC];
  int i_src [NSRC];
  int i_rd;

  function automatic int dsel(int s);
    return int'(bus.ex_fwd_sel[s*FSW +: FSW]);
  endfunction

  function automatic void mdl_eval();
    bit any;
    any = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      int d_hit;
      d_hit = 0;
      for (int d = DEPTH; d >= 1; d--) begin
        if (i_en[s] && i_src[s] != 0 && hist[d-1].v && hist[d-1].wr && hist[d-1].rd == i_src[s])
          d_hit = d;
      end
      if (FWD) begin
        if (d_hit != 0 && hist[d_hit-1].ld && d_hit < int'(LOAD_READY)) any = 1'b1;
        m_sel[s] = (d_hit != 0 && d_hit < int'(DEPTH)) ? d_hit : 0;
      end else begin
        if (d_hit != 0 && d_hit < int'(DEPTH)) any = 1'b1;
        m_sel[s] = 0;
      end
    end
    m_stall = i_v && !i_fl && any;
  endfunction

  function automatic void mdl_reset();
    for (int d = 0; d < DEPTH; d++) hist[d] = '{v: 0, wr: 0, ld: 0, rd: 0};
    for (int s = 0; s < NSRC; s++) m_sel_q[s] = 0;
    m_cnt = 0;
  endfunction

  task automatic put(input bit v, input bit e0, input int s0, input bit e1, input int s1,
                     input bit wr, input int rd, input bit ld,
                     input bit fl = 1'b0, input bit clr = 1'b0);
    i_v = v; i_en[0] = e0; i_src[0] = s0; i_en[1] = e1; i_src[1] = s1;
    i_wr = wr; i_rd = rd; i_ld = ld; i_fl = fl; i_clr = clr;
    bus.id_valid   = v;
    bus.id_src_en  = {e1, e0};
    bus.id_src     = {REG_AW'(s1), REG_AW'(s0)};
    bus.id_wr_en   = wr;
    bus.id_rd      = REG_AW'(rd);
    bus.id_is_load = ld;
    bus.flush      = fl;
    bus.stat_clr   = clr;
    #1;
    mdl_eval();
  endtask

  // Advance the model across the coming edge, then wait for the next negedge
  task automatic tick();
    bit issue;
    issue = i_v && !m_stall && !i_fl;
    if (i_clr) m_cnt = 0;
    else if (m_stall && m_cnt < 65535) m_cnt++;
    for (int s = 0; s < NSRC; s++) m_sel_q[s] = issue ? m_sel[s] : 0;
    for (int d = DEPTH - 1; d >= 1; d--) hist[d] = hist[d-1];
    hist[0] = '{v: issue, wr: issue && i_wr, ld: issue && i_ld, rd: i_rd};
    @(negedge clk);
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      put(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    put(1, 1, 3, 0, 0, 1, 3, 1);
    repeat (2) @(negedge clk);
    #1;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    n_checks++;
    if (bus.ex_fwd_sel !== '0) begin n_fail++; $display("FAIL reset_sel got %h exp 0", bus.ex_fwd_sel); end
    n_checks++;
    if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", bus.stall_cnt); end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    bubble(1);
  endtask

  task automatic test_alu_fwd();
    int ns;
    ns = FWD ? 0 : 2;
    put(1, 1, 1, 1, 2, 1, 3, 0);              // ADD R3,R1,R2
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL alu_producer_stall got %b exp 0", bus.stall); end
    n_checks++;
    tick();
    for (int c = 0; c <= ns; c++) begin
      put(1, 1, 3, 1, 4, 0, 0, 0);            // SUB using R3
      if (bus.stall !== (c < ns)) begin
        n_fail++; $display("FAIL alu_stall c=%0d got %b exp %b", c, bus.stall, c < ns);
      end
      n_checks++;
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    if (dsel(0) !== (FWD ? 1 : 0)) begin n_fail++; $display("FAIL alu_sel0 got %0d exp %0d", dsel(0), FWD ? 1 : 0); end
    n_checks++;
    if (dsel(1) !== 0) begin n_fail++; $display("FAIL alu_sel1 got %0d exp 0", dsel(1)); end
    n_checks++;
    tick();
    bubble(DEPTH);
  endtask

  task automatic test_load_use();
    int ns;
    ns = FWD ? 1 : 2;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);        // clear counter
    tick();
    put(1, 0, 0, 0, 0, 1, 5, 1);              // LW R5
    tick();
    for (int c = 0; c <= ns; c++) begin
      put(1, 1, 5, 1, 6, 0, 0, 0);            // ADD R1,R5,R6
      if (bus.stall !== (c < ns)) begin
        n_fail++; $display("FAIL lu_stall c=%0d got %b exp %b", c, bus.stall, c < ns);
      end
      n_checks++;
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    if (bus.stall_cnt !== 16'(ns)) begin n_fail++; $display("FAIL lu_cnt got %0d exp %0d", bus.stall_cnt, ns); end
    n_checks++;
    if (dsel(0) !== (FWD ? 2 : 0)) begin n_fail++; $display("FAIL lu_sel0 got %0d exp %0d", dsel(0), FWD ? 2 : 0); end
    n_checks++;
    if (dsel(1) !== 0) begin n_fail++; $display("FAIL lu_sel1 got %0d exp 0", dsel(1)); end
    n_checks++;
    tick();
    bubble(DEPTH);
  endtask

  task automatic test_bubble_distance();
    int ns;
    ns = FWD ? 0 : 1;
    put(1, 0, 0, 0, 0, 1, 4, 0);              // ADD R4
    tick();
    bubble(1);
    for (int c = 0; c <= ns; c++) begin
      put(1, 0, 0, 1, 4, 0, 0, 0);            // consumer reads R4 on source 1
      if (bus.stall !== (c < ns)) begin
        n_fail++; $display("FAIL dist2_stall c=%0d got %b exp %b", c, bus.stall, c < ns);
      end
      n_checks++;
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    if (dsel(1) !== (FWD ? 2 : 0)) begin n_fail++; $display("FAIL dist2_sel1 got %0d exp %0d", dsel(1), FWD ? 2 : 0); end
    n_checks++;
    tick();
    bubble(DEPTH);
    put(1, 0, 0, 0, 0, 1, 4, 0);
    tick();
    bubble(2);
    put(1, 0, 0, 1, 4, 0, 0, 0);
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL dist3_stall got %b exp 0", bus.stall); end
    n_checks++;
    tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    if (dsel(1) !== 0) begin n_fail++; $display("FAIL dist3_sel1 got %0d exp 0", dsel(1)); end
    n_checks++;
    tick();
    bubble(DEPTH);
  endtask

  task automatic test_youngest();
    int ns;
    ns = FWD ? 1 : 2;
    put(1, 0, 0, 0, 0, 1, 2, 0); tick();      // ADD R2
    put(1, 0, 0, 0, 0, 1, 2, 1); tick();      // LW R2
    for (int c = 0; c <= ns; c++) begin
      put(1, 1, 2, 0, 0, 0, 0, 0);
      if (bus.stall !== (c < ns)) begin
        n_fail++; $display("FAIL young_ld_stall c=%0d got %b exp %b", c, bus.stall, c < ns);
      end
      n_checks++;
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    if (dsel(0) !== (FWD ? 2 : 0)) begin n_fail++; $display("FAIL young_ld_sel0 got %0d exp %0d", dsel(0), FWD ? 2 : 0); end
    n_checks++;
    tick();
    bubble(DEPTH);
    ns = FWD ? 0 : 2;
    put(1, 0, 0, 0, 0, 1, 2, 0); tick();      // ADD R2
    put(1, 0, 0, 0, 0, 1, 2, 0); tick();      // ADD R2
    for (int c = 0; c <= ns; c++) begin
      put(1, 1, 2, 0, 0, 0, 0, 0);
      if (bus.stall !== (c < ns)) begin
        n_fail++; $display("FAIL young_alu_stall c=%0d got %b exp %b", c, bus.stall, c < ns);
      end
      n_checks++;
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    if (dsel(0) !== (FWD ? 1 : 0)) begin n_fail++; $display("FAIL young_alu_sel0 got %0d exp %0d", dsel(0), FWD ? 1 : 0); end
    n_checks++;
    tick();
    bubble(DEPTH);
  endtask

  task automatic test_r0();
    put(1, 0, 0, 0, 0, 1, 0, 1); tick();      // LW R0
    put(1, 1, 0, 1, 0, 0, 0, 0);
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %b exp 0", bus.stall); end
    n_checks++;
    tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    if (bus.ex_fwd_sel !== '0) begin n_fail++; $display("FAIL r0_sel got %h exp 0", bus.ex_fwd_sel); end
    n_checks++;
    tick();
    bubble(DEPTH);
  endtask

  task automatic test_flush();
    int ns;
    ns = FWD ? 0 : 1;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    put(1, 0, 0, 0, 0, 1, 5, 1); tick();      // LW R5
    put(1, 1, 5, 0, 0, 1, 7, 1, 1);           // LW R7,(R5) squashed
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", bus.stall); end
    n_checks++;
    tick();
    for (int c = 0; c <= ns; c++) begin
      put(1, 1, 7, 1, 5, 0, 0, 0);
      if (bus.stall !== (c < ns)) begin
        n_fail++; $display("FAIL post_flush_stall c=%0d got %b exp %b", c, bus.stall, c < ns);
      end
      n_checks++;
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    if (bus.stall_cnt !== 16'(ns)) begin n_fail++; $display("FAIL flush_cnt got %0d exp %0d", bus.stall_cnt, ns); end
    n_checks++;
    if (dsel(0) !== 0) begin n_fail++; $display("FAIL flush_sel0 got %0d exp 0", dsel(0)); end
    n_checks++;
    if (dsel(1) !== (FWD ? 2 : 0)) begin n_fail++; $display("FAIL flush_sel1 got %0d exp %0d", dsel(1), FWD ? 2 : 0); end
    n_checks++;
    tick();
    bubble(DEPTH);
  endtask

  task automatic test_reset_mid_stall();
    put(1, 0, 0, 0, 0, 1, 5, 1); tick();      // LW R5
    put(1, 1, 5, 0, 0, 0, 0, 0);
    if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stall got %b exp 1", bus.stall); end
    n_checks++;
    #2 rst_n = 1'b0;
    #1;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL async_reset_stall got %b exp 0", bus.stall); end
    n_checks++;
    if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL async_reset_cnt got %0d exp 0", bus.stall_cnt); end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    put(1, 1, 5, 0, 0, 0, 0, 0);
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall got %b exp 0", bus.stall); end
    n_checks++;
    tick();
    bubble(DEPTH);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      put($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7), 1'($urandom),
          $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      if (bus.stall !== m_stall) begin
        n_fail++; $display("FAIL rnd_stall i=%0d got %b exp %b", i, bus.stall, m_stall);
      end
      n_checks++;
      for (int s = 0; s < NSRC; s++) begin
        if (dsel(s) !== m_sel_q[s]) begin
          n_fail++; $display("FAIL rnd_sel%0d i=%0d got %0d exp %0d", s, i, dsel(s), m_sel_q[s]);
        end
        n_checks++;
      end
      if (bus.stall_cnt !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_cnt i=%0d got %0d exp %0d", i, bus.stall_cnt, m_cnt);
      end
      n_checks++;
      tick();
    end
    bubble(DEPTH);
  endtask

  // Self-dependent load held in ID: issues once per (S+1) cycles, S stalls between
  task automatic test_saturation();
    int s_per, per, n, exp_cnt;
    int pts [2];
    pts[0] = 1000;
    pts[1] = 70300;
    s_per = FWD ? int'(S_LR) - 1 : int'(S_DEPTH) - 1;
    per   = s_per + 1;
    n     = 0;
    sbus.id_valid = 1'b1; sbus.id_src_en = 2'b01; sbus.id_src = {REG_AW'(0), REG_AW'(5)};
    sbus.id_wr_en = 1'b1; sbus.id_rd = REG_AW'(5); sbus.id_is_load = 1'b1;
    sbus.flush = 1'b0; sbus.stat_clr = 1'b0;
    @(negedge clk);
    rst_n_sat = 1'b1;
    for (int p = 0; p < 2; p++) begin
      while (n < pts[p]) begin
        @(posedge clk);
        n++;
      end
      #1;
      exp_cnt = (n / per) * s_per + ((n % per) > 0 ? (n % per) - 1 : 0);
      if (exp_cnt > 65535) exp_cnt = 65535;
      if (sbus.stall_cnt !== 16'(exp_cnt)) begin
        n_fail++; $display("FAIL sat_cnt n=%0d got %0d exp %0d", n, sbus.stall_cnt, exp_cnt);
      end
      n_checks++;
      if (sbus.stall !== ((n % per) != 0)) begin
        n_fail++; $display("FAIL sat_stall n=%0d got %b exp %b", n, sbus.stall, (n % per) != 0);
      end
      n_checks++;
    end
    @(negedge clk);
    sbus.stat_clr = 1'b1;
    @(posedge clk);
    #1;
    if (sbus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stat_clr got %0d exp 0", sbus.stall_cnt); end
    n_checks++;
    sbus.stat_clr = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    rst_n_sat = 1'b0;
    sbus.id_valid = 1'b0; sbus.id_src_en = '0; sbus.id_src = '0; sbus.id_wr_en = 1'b0;
    sbus.id_rd = '0; sbus.id_is_load = 1'b0; sbus.flush = 1'b0; sbus.stat_clr = 1'b0;
    mdl_reset();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_bubble_distance();
    test_youngest();
    test_r0();
    test_flush();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
